// File: rtl/mvv_lva_sequencer.sv
// rtl/mvv_lva_sequencer.sv - iterative highest-priority candidate sequencer over a square mask
// Emits masked squares one at a time, highest priority first (lowest index on ties).
module mvv_lva_sequencer #(
    parameter int NSQ      = 64,
    parameter int PW       = 3,
    parameter int PIPE     = 0,
    parameter int MAX_EMIT = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [NSQ-1:0]             mask_in,
    input  logic [NSQ*PW-1:0]          prio_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(NSQ)-1:0]     out_sq,
    output logic [PW-1:0]              out_prio,
    output logic                       busy,
    output logic                       done,
    output logic                       truncated,
    output logic [$clog2(NSQ+1)-1:0]   emit_cnt
);

    localparam int SW = $clog2(NSQ);
    localparam int LV = SW;
    localparam int EW = $clog2(NSQ+1);
    localparam int CW = $clog2(PIPE+2);

    typedef enum logic [1:0] {IDLE, EVAL, OFFER} state_t;

    state_t          state, state_nx;
    logic [NSQ-1:0]  mask;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   win_prio;
    logic [SW-1:0]   win_sq;
    logic            load, take, fin, acc, trunc_nx;

    // Binary max tree; the last PIPE levels (nearest the root) are registered.
    for (genvar l = 0; l <= LV; l++) begin : lvl
        localparam int N = NSQ >> l;
        logic [N*PW-1:0] p;
        logic [N*SW-1:0] s;
        if (l == 0) begin : leaf
            for (genvar i = 0; i < N; i++) begin : sq
                assign p[PW*i +: PW] = mask[i] ? prio_in[PW*i +: PW] : '0;
                assign s[SW*i +: SW] = SW'(i);
            end
        end else begin : node
            logic [N*PW-1:0] cp;
            logic [N*SW-1:0] cs;
            for (genvar i = 0; i < N; i++) begin : pair
                logic rgt;
                // Right (higher index) wins only when strictly greater.
                assign rgt = lvl[l-1].p[PW*(2*i+1) +: PW] > lvl[l-1].p[PW*(2*i) +: PW];
                assign cp[PW*i +: PW] = rgt ? lvl[l-1].p[PW*(2*i+1) +: PW]
                                            : lvl[l-1].p[PW*(2*i) +: PW];
                assign cs[SW*i +: SW] = rgt ? lvl[l-1].s[SW*(2*i+1) +: SW]
                                            : lvl[l-1].s[SW*(2*i) +: SW];
            end
            if (l > LV - PIPE) begin : rg
                always_ff @(posedge clk) begin
                    if (rst) begin
                        p <= '0;
                        s <= '0;
                    end else begin
                        p <= cp;
                        s <= cs;
                    end
                end
            end else begin : cb
                assign p = cp;
                assign s = cs;
            end
        end
    end

    assign win_prio = lvl[LV].p;
    assign win_sq   = lvl[LV].s;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        take     = 1'b0;
        fin      = 1'b0;
        acc      = 1'b0;
        trunc_nx = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = EVAL;
                end
            end
            EVAL: begin
                if (cnt == CW'(PIPE)) begin
                    if (win_prio == '0) begin
                        fin      = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        take     = 1'b1;
                        state_nx = OFFER;
                    end
                end
            end
            OFFER: begin
                if (out_valid && out_ready) begin
                    acc = 1'b1;
                    if (MAX_EMIT != 0 && (32'(emit_cnt) + 32'd1) == MAX_EMIT) begin
                        fin      = 1'b1;
                        trunc_nx = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = EVAL;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        if (abort) begin
            state_nx = IDLE;
            load     = 1'b0;
            take     = 1'b0;
            fin      = 1'b0;
            acc      = 1'b0;
            trunc_nx = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask      <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_sq    <= '0;
            out_prio  <= '0;
            done      <= 1'b0;
            truncated <= 1'b0;
            emit_cnt  <= '0;
        end else begin
            done <= fin;
            if (fin) truncated <= trunc_nx;
            if (abort) begin
                out_valid <= 1'b0;
                mask      <= '0;
            end else begin
                if (state == EVAL) cnt <= cnt + CW'(1);
                if (load) begin
                    mask     <= mask_in;
                    emit_cnt <= '0;
                    cnt      <= '0;
                end
                if (take) begin
                    out_sq    <= win_sq;
                    out_prio  <= win_prio;
                    out_valid <= 1'b1;
                end
                if (acc) begin
                    mask[out_sq] <= 1'b0;
                    out_valid    <= 1'b0;
                    cnt          <= '0;
                    if (emit_cnt != EW'(NSQ)) emit_cnt <= emit_cnt + EW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mvv_lva_sequencer.sv
// tb/tb_mvv_lva_sequencer.sv - directed self-checking bench for mvv_lva_sequencer
// Three instances: [0] PIPE=0, [1] PIPE=0 MAX_EMIT=2, [2] PIPE=3.
module tb_mvv_lva_sequencer;

    localparam int NSQ = 64;
    localparam int PW  = 3;

    logic clk = 1'b0;
    logic rst, abort, out_ready;
    logic [2:0]        start;
    logic [NSQ-1:0]    mask_in;
    logic [NSQ*PW-1:0] prio_in;
    logic              ov [3];
    logic              bz [3];
    logic              dn [3];
    logic              tr [3];
    logic [5:0]        osq [3];
    logic [2:0]        opr [3];
    logic [6:0]        ec [3];

    int checks = 0;
    int passed = 0;
    int rec_sq[$];
    int rec_pr[$];
    int rec_c[$];
    int done_c;
    bit overlap;

    always #5 clk = ~clk;

    mvv_lva_sequencer #(.NSQ(NSQ), .PW(PW), .PIPE(0), .MAX_EMIT(0)) u0 (
        .clk(clk), .rst(rst), .start(start[0]), .abort(abort), .mask_in(mask_in),
        .prio_in(prio_in), .out_valid(ov[0]), .out_ready(out_ready), .out_sq(osq[0]),
        .out_prio(opr[0]), .busy(bz[0]), .done(dn[0]), .truncated(tr[0]), .emit_cnt(ec[0]));

    mvv_lva_sequencer #(.NSQ(NSQ), .PW(PW), .PIPE(0), .MAX_EMIT(2)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .abort(abort), .mask_in(mask_in),
        .prio_in(prio_in), .out_valid(ov[1]), .out_ready(out_ready), .out_sq(osq[1]),
        .out_prio(opr[1]), .busy(bz[1]), .done(dn[1]), .truncated(tr[1]), .emit_cnt(ec[1]));

    mvv_lva_sequencer #(.NSQ(NSQ), .PW(PW), .PIPE(3), .MAX_EMIT(0)) u2 (
        .clk(clk), .rst(rst), .start(start[2]), .abort(abort), .mask_in(mask_in),
        .prio_in(prio_in), .out_valid(ov[2]), .out_ready(out_ready), .out_sq(osq[2]),
        .out_prio(opr[2]), .busy(bz[2]), .done(dn[2]), .truncated(tr[2]), .emit_cnt(ec[2]));

    // Pulses start on instance d and logs accepted candidates; c counts edges after the start edge.
    task automatic run_seq(input int d, input int lim);
        rec_sq.delete();
        rec_pr.delete();
        rec_c.delete();
        done_c  = -1;
        overlap = 1'b0;
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        for (int c = 0; c < lim; c++) begin
            if (ov[d] && dn[d]) overlap = 1'b1;
            if (ov[d] && out_ready) begin
                rec_sq.push_back(int'(osq[d]));
                rec_pr.push_back(int'(opr[d]));
                rec_c.push_back(c);
            end
            if (dn[d]) begin
                done_c = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; abort = 1'b0; out_ready = 1'b0; start = '0;
        mask_in = '0; prio_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ov[d] !== 1'b0 || bz[d] !== 1'b0 || dn[d] !== 1'b0 || tr[d] !== 1'b0 ||
                osq[d] !== 6'd0 || opr[d] !== 3'd0 || ec[d] !== 7'd0)
                $display("FAIL reset%0d got v%b b%b d%b t%b sq%0d p%0d e%0d want all 0",
                         d, ov[d], bz[d], dn[d], tr[d], osq[d], opr[d], ec[d]);
            else passed++;
        end
    endtask

    task automatic test_basic();
        int esq[2] = '{12, 40};
        int epr[2] = '{6, 2};
        int ec_[2] = '{1, 3};
        mask_in = '1; prio_in = '0;
        prio_in[PW*12 +: PW] = 3'd6;
        prio_in[PW*40 +: PW] = 3'd2;
        out_ready = 1'b1;
        run_seq(0, 20);
        checks++;
        if (rec_sq.size() != 2) $display("FAIL basic_count got %0d want 2", rec_sq.size());
        else passed++;
        for (int i = 0; i < 2 && i < rec_sq.size(); i++) begin
            checks++;
            if (rec_sq[i] != esq[i] || rec_pr[i] != epr[i] || rec_c[i] != ec_[i])
                $display("FAIL basic_emit%0d got sq%0d p%0d c%0d want sq%0d p%0d c%0d",
                         i, rec_sq[i], rec_pr[i], rec_c[i], esq[i], epr[i], ec_[i]);
            else passed++;
        end
        checks++;
        if (done_c != 5 || ec[0] !== 7'd2 || tr[0] !== 1'b0 || overlap)
            $display("FAIL basic_done got c%0d e%0d t%b ov%b want c5 e2 t0 ov0",
                     done_c, ec[0], tr[0], overlap);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_tie();
        int esq[3] = '{3, 9, 60};
        int ec_[3] = '{1, 3, 5};
        mask_in = '1; prio_in = '0;
        prio_in[PW*3 +: PW]  = 3'd4;
        prio_in[PW*9 +: PW]  = 3'd4;
        prio_in[PW*60 +: PW] = 3'd4;
        out_ready = 1'b1;
        run_seq(0, 20);
        checks++;
        if (rec_sq.size() != 3) $display("FAIL tie_count got %0d want 3", rec_sq.size());
        else passed++;
        for (int i = 0; i < 3 && i < rec_sq.size(); i++) begin
            checks++;
            if (rec_sq[i] != esq[i] || rec_pr[i] != 4 || rec_c[i] != ec_[i])
                $display("FAIL tie_emit%0d got sq%0d p%0d c%0d want sq%0d p4 c%0d",
                         i, rec_sq[i], rec_pr[i], rec_c[i], esq[i], ec_[i]);
            else passed++;
        end
        checks++;
        if (done_c != 7 || ec[0] !== 7'd3)
            $display("FAIL tie_done got c%0d e%0d want c7 e3", done_c, ec[0]);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        mask_in = '1; prio_in = '0;
        prio_in[PW*20 +: PW] = 3'd5;
        out_ready = 1'b0;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (ov[0] !== 1'b1 || osq[0] !== 6'd20 || opr[0] !== 3'd5 || ec[0] !== 7'd0)
                $display("FAIL bp_hold%0d got v%b sq%0d p%0d e%0d want v1 sq20 p5 e0",
                         k, ov[0], osq[0], opr[0], ec[0]);
            else passed++;
            if (k < 5) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ov[0] !== 1'b0 || ec[0] !== 7'd1)
            $display("FAIL bp_accept got v%b e%0d want v0 e1", ov[0], ec[0]);
        else passed++;
        @(negedge clk);
        checks++;
        if (dn[0] !== 1'b1 || ec[0] !== 7'd1)
            $display("FAIL bp_done got d%b e%0d want d1 e1", dn[0], ec[0]);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_max_emit();
        mask_in = '1; prio_in = '0;
        prio_in[PW*1 +: PW]  = 3'd1;
        prio_in[PW*2 +: PW]  = 3'd7;
        prio_in[PW*5 +: PW]  = 3'd3;
        prio_in[PW*63 +: PW] = 3'd7;
        out_ready = 1'b1;
        run_seq(1, 20);
        checks++;
        if (rec_sq.size() != 2 || rec_sq[0] != 2 || rec_c[0] != 1 || rec_sq[1] != 63 || rec_c[1] != 3)
            $display("FAIL maxemit_order got n%0d first sq%0d want n2 sq2@1 sq63@3",
                     rec_sq.size(), (rec_sq.size() > 0) ? rec_sq[0] : -1);
        else passed++;
        checks++;
        if (done_c != 4 || tr[1] !== 1'b1 || ec[1] !== 7'd2)
            $display("FAIL maxemit_done got c%0d t%b e%0d want c4 t1 e2", done_c, tr[1], ec[1]);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_pipe3();
        mask_in = '1; prio_in = '0;
        prio_in[PW*12 +: PW] = 3'd6;
        prio_in[PW*40 +: PW] = 3'd2;
        out_ready = 1'b1;
        run_seq(2, 40);
        checks++;
        if (rec_sq.size() != 2 || rec_sq[0] != 12 || rec_c[0] != 4 || rec_sq[1] != 40 || rec_c[1] != 9)
            $display("FAIL pipe3_emits got n%0d c0=%0d want n2 sq12@4 sq40@9",
                     rec_sq.size(), (rec_c.size() > 0) ? rec_c[0] : -1);
        else passed++;
        checks++;
        if (done_c != 14 || ec[2] !== 7'd2)
            $display("FAIL pipe3_done got c%0d e%0d want c14 e2", done_c, ec[2]);
        else passed++;
        @(negedge clk);
        mask_in = '0;
        run_seq(2, 20);
        checks++;
        if (rec_sq.size() != 0 || done_c != 4 || tr[2] !== 1'b0)
            $display("FAIL pipe3_empty got n%0d c%0d t%b want n0 c4 t0", rec_sq.size(), done_c, tr[2]);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_abort();
        bit seen_done;
        mask_in = '1; prio_in = '0;
        prio_in[PW*7 +: PW] = 3'd3;
        prio_in[PW*8 +: PW] = 3'd2;
        out_ready = 1'b1;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ov[0] !== 1'b1 || osq[0] !== 6'd8 || ec[0] !== 7'd1)
            $display("FAIL abort_pre got v%b sq%0d e%0d want v1 sq8 e1", ov[0], osq[0], ec[0]);
        else passed++;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (ov[0] !== 1'b0 || bz[0] !== 1'b0 || ec[0] !== 7'd1 || dn[0] !== 1'b0)
            $display("FAIL abort_post got v%b b%b e%0d d%b want v0 b0 e1 d0", ov[0], bz[0], ec[0], dn[0]);
        else passed++;
        seen_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (dn[0]) seen_done = 1'b1;
        end
        checks++;
        if (seen_done) $display("FAIL abort_nodone got done=1 want 0");
        else passed++;
        prio_in = '0;
        prio_in[PW*7 +: PW] = 3'd3;
        out_ready = 1'b0;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        mask_in = '0;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        checks++;
        if (ov[0] !== 1'b1 || osq[0] !== 6'd7 || bz[0] !== 1'b1)
            $display("FAIL busy_start got v%b sq%0d b%b want v1 sq7 b1", ov[0], osq[0], bz[0]);
        else passed++;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (dn[0] !== 1'b1 || ec[0] !== 7'd1)
            $display("FAIL busy_done got d%b e%0d want d1 e1", dn[0], ec[0]);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        mask_in = '1; prio_in = '0;
        prio_in[PW*12 +: PW] = 3'd6;
        out_ready = 1'b1;
        start[2] = 1'b1;
        @(negedge clk);
        start[2] = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (ec[2] !== 7'd1 || ov[2] !== 1'b0 || bz[2] !== 1'b1 || opr[2] !== 3'd6)
            $display("FAIL rstmid_pre got e%0d v%b b%b p%0d want e1 v0 b1 p6", ec[2], ov[2], bz[2], opr[2]);
        else passed++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (ov[2] !== 1'b0 || bz[2] !== 1'b0 || dn[2] !== 1'b0 || tr[2] !== 1'b0 ||
            osq[2] !== 6'd0 || opr[2] !== 3'd0 || ec[2] !== 7'd0)
            $display("FAIL rstmid_post got v%b b%b d%b t%b sq%0d p%0d e%0d want all 0",
                     ov[2], bz[2], dn[2], tr[2], osq[2], opr[2], ec[2]);
        else passed++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_backpressure();
        test_max_emit();
        test_pipe3();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
